// File: rtl/arb_pkg.sv
// Shared constants for the unified memory arbiter: FSM state encoding,
// requester port indices and the read-latency counter width.
package arb_pkg;

  typedef logic [1:0] arb_state_t;

  localparam arb_state_t ST_IDLE  = 2'd0;
  localparam arb_state_t ST_ISSUE = 2'd1;
  localparam arb_state_t ST_WAIT  = 2'd2;

  localparam int PORT_IF   = 0;
  localparam int PORT_DATA = 1;

  localparam int LAT_W = 4;

endpackage

// File: rtl/rr_pick2.sv
// Combinational two-way winner picker.
// Build option ARB_FIXED_PRIO_EN: when defined, the data port always wins a
// tie (keeps a load/store ahead of the next fetch); when undefined, a tie goes
// to the port that did not win last time.
module rr_pick2
  import arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_winner,
  output logic       winner
);

  // Single request wins outright; a tie is resolved by the build-time policy.
  always_comb begin
    winner = 1'(PORT_IF);
    case (req)
      2'b01:   winner = 1'(PORT_IF);
      2'b10:   winner = 1'(PORT_DATA);
`ifdef ARB_FIXED_PRIO_EN
      2'b11:   winner = 1'(PORT_DATA);
`else
      2'b11:   winner = ~last_winner;
`endif
      default: winner = 1'(PORT_IF);
    endcase
  end

endmodule

// File: rtl/unified_mem_arbiter.sv
// Two-port arbiter in front of a single-port synchronous unified memory.
// Port 0 is instruction fetch, port 1 is data load/store. One command is in
// flight at a time; reads wait MEM_LATENCY cycles (1..15) after the issue edge
// and return data with a one-cycle rvalid pulse to the winning port.
// Tie policy is selected by ARB_FIXED_PRIO_EN (see rr_pick2).
//
// Handshake: a port holds req high until its gnt bit pulses; gnt means the
// command was presented to memory in that cycle. A req still high in the cycle
// after gnt is a new request. All outputs are registered; dbg_state mirrors
// the FSM state register.
module unified_mem_arbiter
  import arb_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MEM_LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        req,
  input  logic [1:0]        we,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic [1:0]        gnt,
  output logic [1:0]        rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [1:0]        dbg_state
);

  localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(MEM_LATENCY);

  arb_state_t        state_q, state_d;
  logic              last_winner_q;
  logic              win_q;
  logic [LAT_W-1:0]  cnt_q;
  logic              pick;
  logic              sel;

  logic [1:0]        gnt_d, rvalid_d;
  logic              mem_en_d, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_d, rdata_d;

  rr_pick2 u_pick (
    .req         (req),
    .last_winner (last_winner_q),
    .winner      (pick)
  );

  assign sel       = (state_q == ST_IDLE) && (req != 2'b00);
  assign dbg_state = state_q;

  // State register plus selection bookkeeping and the read-latency counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      last_winner_q <= 1'b1;
      win_q         <= 1'b0;
      cnt_q         <= '0;
    end else begin
      state_q <= state_d;
      if (sel) begin
        last_winner_q <= pick;
        win_q         <= pick;
      end
      if (state_q == ST_ISSUE) begin
        cnt_q <= LAT_INIT;
      end else if (state_q == ST_WAIT) begin
        cnt_q <= cnt_q - 1'b1;
      end
    end
  end

  // Next-state: issue lasts one cycle; only reads go on to wait out latency.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (req != 2'b00) state_d = ST_ISSUE;
      ST_ISSUE: state_d = mem_we ? ST_IDLE : ST_WAIT;
      ST_WAIT:  if (cnt_q == LAT_W'(1)) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Next values of the registered outputs: the command latched at selection
  // appears during ISSUE; read data is captured on the last WAIT cycle.
  always_comb begin
    gnt_d       = 2'b00;
    rvalid_d    = 2'b00;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr;
    mem_wdata_d = mem_wdata;
    rdata_d     = rdata;
    case (state_q)
      ST_IDLE: begin
        if (sel) begin
          mem_en_d    = 1'b1;
          mem_we_d    = pick ? we[1] : we[0];
          mem_addr_d  = pick ? addr1 : addr0;
          mem_wdata_d = pick ? wdata1 : wdata0;
          gnt_d       = pick ? 2'b10 : 2'b01;
        end
      end
      ST_WAIT: begin
        if (cnt_q == LAT_W'(1)) begin
          rdata_d  = mem_rdata;
          rvalid_d = win_q ? 2'b10 : 2'b01;
        end
      end
      default: ;
    endcase
  end

  // Output registers; reset clears everything and drops any pending result.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gnt       <= 2'b00;
      rvalid    <= 2'b00;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      rdata     <= '0;
    end else begin
      gnt       <= gnt_d;
      rvalid    <= rvalid_d;
      mem_en    <= mem_en_d;
      mem_we    <= mem_we_d;
      mem_addr  <= mem_addr_d;
      mem_wdata <= mem_wdata_d;
      rdata     <= rdata_d;
    end
  end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed bench for unified_mem_arbiter: one instance at MEM_LATENCY=1 and
// one at MEM_LATENCY=3, each with a small behavioural memory. Honours
// ARB_FIXED_PRIO_EN for the tie-order expectations.
module tb_unified_mem_arbiter;
  import arb_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  logic mem_clr;
  always #5 clk = ~clk;

  // ---------------- DUT (latency 1) ----------------
  logic [1:0]  req, we, gnt, rvalid, dbg_state;
  logic [31:0] addr0, addr1, wdata0, wdata1, rdata;
  logic        mem_en, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  unified_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(1)) dut (
    .clk(clk), .reset(reset), .req(req), .we(we),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .dbg_state(dbg_state)
  );

  // ---------------- DUT (latency 3) ----------------
  logic [1:0]  x_req, x_we, x_gnt, x_rvalid, x_dbg_state;
  logic [31:0] x_addr0, x_addr1, x_wdata0, x_wdata1, x_rdata;
  logic        x_mem_en, x_mem_we;
  logic [31:0] x_mem_addr, x_mem_wdata, x_mem_rdata;

  unified_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(3)) dut3 (
    .clk(clk), .reset(reset), .req(x_req), .we(x_we),
    .addr0(x_addr0), .addr1(x_addr1), .wdata0(x_wdata0), .wdata1(x_wdata1),
    .gnt(x_gnt), .rvalid(x_rvalid), .rdata(x_rdata),
    .mem_en(x_mem_en), .mem_we(x_mem_we), .mem_addr(x_mem_addr),
    .mem_wdata(x_mem_wdata), .mem_rdata(x_mem_rdata), .dbg_state(x_dbg_state)
  );

  // ---------------- memory models ----------------
  logic [255:0] wr_v;
  logic [31:0]  wr_a [0:255];
  logic [31:0]  p3 [0:2];

  function automatic logic [31:0] mem_val(input logic [31:0] a);
    case (a)
      32'h10:  return 32'h3C08_ABCD;
      32'h20:  return 32'hA5A5_0020;
      32'h40:  return 32'h0000_C0DE;
      default: return a ^ 32'h5A5A_5A5A;
    endcase
  endfunction

  function automatic logic [31:0] rd_lookup(input logic [31:0] a);
    return wr_v[a[9:2]] ? wr_a[a[9:2]] : mem_val(a);
  endfunction

  always @(posedge clk) begin
    if (mem_clr) wr_v <= '0;
    else if (mem_en && mem_we) begin
      wr_v[mem_addr[9:2]] <= 1'b1;
      wr_a[mem_addr[9:2]] <= mem_wdata;
    end
    mem_rdata <= (mem_en && !mem_we) ? rd_lookup(mem_addr) : 32'hDEAD_0BAD;
  end

  always @(posedge clk) begin
    p3[0] <= (x_mem_en && !x_mem_we) ? mem_val(x_mem_addr) : 32'hDEAD_0BAD;
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end
  assign x_mem_rdata = p3[2];

  // ---------------- checking ----------------
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- scoreboard: read results on the latency-1 DUT ----------------
  logic [32:0] exp_q[$];
  logic [32:0] e;
  int rv_cnt = 0;
  int rv1_cnt = 0;

  always @(negedge clk) begin
    if (reset) begin
      exp_q.delete();
    end else begin
      if (gnt != 2'b00 && !mem_we) exp_q.push_back({gnt[1], rd_lookup(mem_addr)});
      if (rvalid != 2'b00) begin
        rv_cnt <= rv_cnt + 1;
        if (rvalid[1]) rv1_cnt <= rv1_cnt + 1;
        if (exp_q.size() == 0) begin
          check("rvalid_unexpected", 64'(rvalid), 64'(0));
        end else begin
          e = exp_q.pop_front();
          check("rvalid_port", 64'(rvalid), e[32] ? 64'(2'b10) : 64'(2'b01));
          check("rvalid_rdata", 64'(rdata), 64'(e[31:0]));
        end
      end
    end
  end

  // ---------------- driver helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  int base, rem0, rem1, g1, g2, rv_first, rvn;
  int ord_q[$];
  int exp_ord[6];
  logic [31:0] cap;

  initial begin
    reset = 1'b1; mem_clr = 1'b1;
    req = '0; we = '0; addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    x_req = '0; x_we = '0; x_addr0 = '0; x_addr1 = '0; x_wdata0 = '0; x_wdata1 = '0;
    repeat (3) tick();

    // Reset state
    check("rst_ctl", 64'({gnt, rvalid, mem_en, mem_we}), 64'(0));
    check("rst_addr", 64'(mem_addr), 64'(0));
    check("rst_wdata", 64'(mem_wdata), 64'(0));
    check("rst_rdata", 64'(rdata), 64'(0));
    check("rst_state", 64'(dbg_state), 64'(ST_IDLE));
    reset = 1'b0; mem_clr = 1'b0;
    tick();

    // Single read from port 0, latency 1
    base = rv1_cnt;
    req = 2'b01; we = 2'b00; addr0 = 32'h10;
    tick();
    check("t1_gnt", 64'(gnt), 64'(2'b01));
    check("t1_en_we", 64'({mem_en, mem_we}), 64'(2'b10));
    check("t1_addr", 64'(mem_addr), 64'(32'h10));
    req = 2'b00;
    tick();
    check("t1_rv_early", 64'(rvalid), 64'(0));
    tick();
    check("t1_rv", 64'(rvalid), 64'(2'b01));
    check("t1_rdata", 64'(rdata), 64'(32'h3C08_ABCD));
    tick();
    check("t1_rv_width", 64'(rvalid), 64'(0));
    check("t1_no_rv1", 64'(rv1_cnt - base), 64'(0));

    // Single write from port 1
    base = rv_cnt;
    req = 2'b10; we = 2'b10; addr1 = 32'h100; wdata1 = 32'hDEAD_BEEF;
    tick();
    check("t2_cmd", 64'({gnt, mem_en, mem_we}), 64'(4'b1011));
    check("t2_addr", 64'(mem_addr), 64'(32'h100));
    check("t2_wdata", 64'(mem_wdata), 64'(32'hDEAD_BEEF));
    req = 2'b00; we = 2'b00;
    tick();
    check("t2_idle", 64'({gnt, mem_en, mem_we, rvalid}), 64'(0));
    check("t2_addr_hold", 64'(mem_addr), 64'(32'h100));
    repeat (3) tick();
    check("t2_no_rv", 64'(rv_cnt - base), 64'(0));

    // Simultaneous reads, three each, first tie after reset
    reset = 1'b1; tick(); reset = 1'b0; tick();
`ifdef ARB_FIXED_PRIO_EN
    exp_ord = '{1, 1, 1, 0, 0, 0};
`else
    exp_ord = '{0, 1, 0, 1, 0, 1};
`endif
    req = 2'b11; we = 2'b00; addr0 = 32'h10; addr1 = 32'h20;
    rem0 = 3; rem1 = 3;
    for (int c = 0; c < 60 && (rem0 + rem1) > 0; c++) begin
      tick();
      if (gnt[0]) begin ord_q.push_back(0); rem0--; if (rem0 == 0) req[0] = 1'b0; end
      if (gnt[1]) begin ord_q.push_back(1); rem1--; if (rem1 == 0) req[1] = 1'b0; end
    end
    req = 2'b00;
    check("t3_count", 64'(ord_q.size()), 64'(6));
    for (int i = 0; i < 6; i++) begin
      check($sformatf("t3_ord%0d", i), 64'((i < ord_q.size()) ? ord_q[i] : 9), 64'(exp_ord[i]));
    end
    repeat (5) tick();

    // Reset during WAIT of a read
    req = 2'b01; we = 2'b00; addr0 = 32'h10;
    tick();
    check("t5_gnt", 64'(gnt), 64'(2'b01));
    req = 2'b00;
    tick();
    check("t5_in_wait", 64'(dbg_state), 64'(ST_WAIT));
    reset = 1'b1;
    #1;
    check("t5_rst_ctl", 64'({gnt, rvalid, mem_en, mem_we}), 64'(0));
    check("t5_rst_addr", 64'(mem_addr), 64'(0));
    check("t5_rst_rdata", 64'(rdata), 64'(0));
    check("t5_rst_state", 64'(dbg_state), 64'(ST_IDLE));
    base = rv_cnt;
    tick();
    reset = 1'b0;
    repeat (4) tick();
    check("t5_no_rv", 64'(rv_cnt - base), 64'(0));
    req = 2'b11; addr0 = 32'h10; addr1 = 32'h20;
    tick();
`ifdef ARB_FIXED_PRIO_EN
    check("t5_tie", 64'(gnt), 64'(2'b10));
`else
    check("t5_tie", 64'(gnt), 64'(2'b01));
`endif
    req = req & ~gnt;
    for (int c = 0; c < 10 && req != 2'b00; c++) begin
      tick();
      req = req & ~gnt;
    end
    check("t5_second_gnt", 64'(req), 64'(0));
    req = 2'b00;
    repeat (5) tick();

    // Back-to-back write then read on port 1
    req = 2'b10; we = 2'b10; addr1 = 32'h200; wdata1 = 32'h1234_5678;
    tick();
    check("t6_wr_gnt", 64'({gnt, mem_we}), 64'(3'b101));
    we = 2'b00;
    tick();
    check("t6_gap", 64'(gnt), 64'(0));
    tick();
    check("t6_rd_gnt", 64'({gnt, mem_we}), 64'(3'b100));
    check("t6_rd_addr", 64'(mem_addr), 64'(32'h200));
    req = 2'b00;
    tick();
    tick();
    check("t6_rv", 64'(rvalid), 64'(2'b10));
    check("t6_rdata", 64'(rdata), 64'(32'h1234_5678));
    repeat (3) tick();

    // Latency 3: request first seen in IDLE at cycle 0
    g1 = 0; g2 = 0; rv_first = 0; rvn = 0; cap = '0;
    x_req = 2'b01; x_we = 2'b00; x_addr0 = 32'h40;
    for (int c = 1; c <= 8; c++) begin
      tick();
      if (x_gnt[0]) begin
        if (g1 == 0) g1 = c;
        else if (g2 == 0) g2 = c;
      end
      if (x_rvalid[0]) begin
        rvn++;
        if (rv_first == 0) begin rv_first = c; cap = x_rdata; end
      end
    end
    x_req = 2'b00;
    check("t4_gnt_cycle", 64'(g1), 64'(1));
    check("t4_rv_cycle", 64'(rv_first), 64'(5));
    check("t4_rv_width", 64'(rvn), 64'(1));
    check("t4_rdata", 64'(cap), 64'(32'h0000_C0DE));
    check("t4_next_gnt", 64'(g2), 64'(6));
    repeat (8) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
